infinite_mem_traffic_gen: RTL

Initiator-side counterpart to the infinite-memory request path. The block generates a programmed stream of remote request packets (load, store, amoswap, amoor) toward one destination tile. It uses a valid/ready handshake and bounds the number of in-flight requests with a credit counter. It consumes responses on the return path and reports completion, so a bench can drive infinite-memory models and their profilers with known op counts.

---
 rtl/infinite_mem_traffic_gen_if.sv | 45 ++++
 rtl/infinite_mem_traffic_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/infinite_mem_traffic_gen_if.sv
// Request/return bus between the traffic generator and an infinite-memory model.
// The op package lives here so both the interface and the generator can see it.
package infinite_mem_traffic_gen_pkg;
  typedef enum logic [1:0] {
    e_remote_load    = 2'd0,
    e_remote_store   = 2'd1,
    e_remote_amoswap = 2'd2,
    e_remote_amoor   = 2'd3
  } bsg_manycore_packet_op_e;
endpackage

interface infinite_mem_traffic_gen_if #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7
);
  import infinite_mem_traffic_gen_pkg::*;

  logic                          packet_v_o;
  logic                          packet_ready_i;
  bsg_manycore_packet_op_e       packet_op_o;
  logic [addr_width_p-1:0]       packet_addr_o;
  logic [data_width_p-1:0]       packet_data_o;
  logic [x_cord_width_p-1:0]     packet_dst_x_o;
  logic [y_cord_width_p-1:0]     packet_dst_y_o;
  logic [x_cord_width_p-1:0]     packet_src_x_o;
  logic [y_cord_width_p-1:0]     packet_src_y_o;
  logic                          return_v_i;
  logic                          return_yumi_o;

  modport master (
    output packet_v_o, packet_op_o, packet_addr_o,
    output packet_data_o, packet_dst_x_o, packet_dst_y_o,
    output packet_src_x_o, packet_src_y_o, return_yumi_o,
    input  packet_ready_i, return_v_i
  );

  modport slave (
    input  packet_v_o, packet_op_o, packet_addr_o,
    input  packet_data_o, packet_dst_x_o, packet_dst_y_o,
    input  packet_src_x_o, packet_src_y_o, return_yumi_o,
    output packet_ready_i, return_v_i
  );
endinterface

// File: rtl/infinite_mem_traffic_gen.sv
// Credit-limited request stream generator for infinite-memory models.
// Issues num_req packets, drains the returns, then reports done.
module infinite_mem_traffic_gen
  import infinite_mem_traffic_gen_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int max_out_p      = 8,
  parameter int count_width_p  = 16,
  localparam int out_w_lp      = $clog2(max_out_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic [count_width_p-1:0]  num_req_i,
  input  logic [addr_width_p-1:0]   base_addr_i,
  input  logic [addr_width_p-1:0]   stride_i,
  input  logic [1:0]                op_mode_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  infinite_mem_traffic_gen_if.master pkt,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [count_width_p-1:0]  issued_o,
  output logic [count_width_p-1:0]  returned_o,
  output logic [out_w_lp-1:0]       outstanding_o,
  output logic                      error_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                r_state;
  logic [count_width_p-1:0]  r_num_req;
  logic [addr_width_p-1:0]   r_addr;
  logic [addr_width_p-1:0]   r_stride;
  logic [1:0]                r_mode;
  logic [x_cord_width_p-1:0] r_dst_x;
  logic [y_cord_width_p-1:0] r_dst_y;
  logic [x_cord_width_p-1:0] r_src_x;
  logic [y_cord_width_p-1:0] r_src_y;
  logic [count_width_p-1:0]  r_issued;
  logic [count_width_p-1:0]  r_returned;
  logic [out_w_lp-1:0]       r_out;
  logic                      r_err;

  logic                      w_start;
  logic                      w_v;
  logic                      w_fire;
  logic                      w_yumi;
  logic                      w_last;
  logic [out_w_lp-1:0]       w_out_nxt;
  bsg_manycore_packet_op_e   w_op;

  assign w_start = start_i
                 & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_v     = (r_state == S_ISSUE)
                 & (r_out < out_w_lp'(max_out_p));
  assign w_fire  = w_v & pkt.packet_ready_i;
  assign w_yumi  = pkt.return_v_i & (r_out != '0);
  assign w_last  = (r_issued + 1'b1) == r_num_req;

  // Simultaneous fire and yumi cancel, keeping a credit free at max-1.
  always_comb begin
    w_out_nxt = r_out;
    if (w_fire & ~w_yumi)
      w_out_nxt = r_out + 1'b1;
    else if (~w_fire & w_yumi)
      w_out_nxt = r_out - 1'b1;
  end

  always_comb begin
    w_op = e_remote_load;
    unique case (1'b1)
      (r_mode == 2'd0): w_op = e_remote_load;
      (r_mode == 2'd1): w_op = e_remote_store;
      (r_mode == 2'd2):
        w_op = r_issued[0] ? e_remote_load : e_remote_store;
      (r_mode == 2'd3):
        w_op = bsg_manycore_packet_op_e'(r_issued[1:0]);
      default: w_op = e_remote_load;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_num_req  <= '0;
      r_addr     <= '0;
      r_stride   <= '0;
      r_mode     <= '0;
      r_dst_x    <= '0;
      r_dst_y    <= '0;
      r_src_x    <= '0;
      r_src_y    <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (w_yumi)
        r_returned <= r_returned + 1'b1;
      if (pkt.return_v_i & (r_out == '0))
        r_err <= 1'b1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_num_req  <= num_req_i;
            r_addr     <= base_addr_i;
            r_stride   <= stride_i;
            r_mode     <= op_mode_i;
            r_dst_x    <= dest_x_i;
            r_dst_y    <= dest_y_i;
            r_src_x    <= my_x_i;
            r_src_y    <= my_y_i;
            r_issued   <= '0;
            r_returned <= '0;
            r_out      <= '0;
            r_err      <= 1'b0;
            r_state    <= (num_req_i == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_fire) begin
            r_issued <= r_issued + 1'b1;
            r_addr   <= r_addr + r_stride;
            if (w_last)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_nxt == '0)
            r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pkt.packet_v_o     = w_v;
  assign pkt.packet_op_o    = w_op;
  assign pkt.packet_addr_o  = r_addr;
  assign pkt.packet_data_o  = data_width_p'(r_issued);
  assign pkt.packet_dst_x_o = r_dst_x;
  assign pkt.packet_dst_y_o = r_dst_y;
  assign pkt.packet_src_x_o = r_src_x;
  assign pkt.packet_src_y_o = r_src_y;
  assign pkt.return_yumi_o  = w_yumi;

  assign busy_o        = (r_state == S_ISSUE) | (r_state == S_DRAIN);
  assign done_o        = (r_state == S_DONE);
  assign issued_o      = r_issued;
  assign returned_o    = r_returned;
  assign outstanding_o = r_out;
  assign error_o       = r_err;

endmodule
